// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and the ALU it feeds:
// datapath widths, the hardwired zero register and the ALU function codes.
package reg_file_pkg;

    localparam int BW_DATA  = 32;
    localparam int BW_ADDR  = 5;
    localparam int NUM_REG  = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_func_e;

    // Reference ALU result, so issue and write-back decode from one source.
    function automatic logic [BW_DATA-1:0] alu_eval(input alu_func_e f,
                                                    input logic [BW_DATA-1:0] a,
                                                    input logic [BW_DATA-1:0] b);
        logic [BW_DATA-1:0] y;
        y = '0;
        case (f)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_ANDN: y = a & ~b;
            ALU_ORN:  y = a | ~b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = ($signed(a) < $signed(b)) ? BW_DATA'(1) : '0;
            default:  y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/reg_file_fwd.sv
// Per-port read value selection: register zero, same-edge write forwarding,
// or the stored array entry.
module reg_file_fwd
    import reg_file_pkg::*;
#(
    parameter int BW_DATA = reg_file_pkg::BW_DATA,
    parameter int BW_ADDR = reg_file_pkg::BW_ADDR,
    parameter int BYPASS  = 1
) (
    input  logic [BW_ADDR-1:0] i_addr,
    input  logic [BW_DATA-1:0] i_entry,
    input  logic               i_we,
    input  logic [BW_ADDR-1:0] i_waddr,
    input  logic [BW_DATA-1:0] i_wdata,
    output logic [BW_DATA-1:0] o_value
);

    logic w_is_zero;
    logic w_fwd_hit;

    assign w_is_zero = (i_addr == BW_ADDR'(REG_ZERO));
    assign w_fwd_hit = (BYPASS != 0) && i_we && (i_waddr == i_addr);

    // Zero wins over forwarding so a write to r0 can never leak through.
    always_comb begin
        o_value = i_entry;
        if (w_is_zero) begin
            o_value = '0;
        end else if (w_fwd_hit) begin
            o_value = i_wdata;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 2-read / 1-write register file with registered, valid-qualified read
// ports feeding the ALU operands; r0 reads as zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int BW_DATA = reg_file_pkg::BW_DATA,
    parameter int NUM_REG = reg_file_pkg::NUM_REG,
    parameter int BW_ADDR = reg_file_pkg::BW_ADDR,
    parameter int BYPASS  = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_we,
    input  logic [BW_ADDR-1:0] i_waddr,
    input  logic [BW_DATA-1:0] i_wdata,
    input  logic               i_re,
    input  logic [BW_ADDR-1:0] i_raddr_a,
    input  logic [BW_ADDR-1:0] i_raddr_b,
    output logic [BW_DATA-1:0] o_rdata_a,
    output logic [BW_DATA-1:0] o_rdata_b,
    output logic               o_rvalid
);

    logic [BW_DATA-1:0] r_mem [NUM_REG];
    logic [BW_DATA-1:0] r_rdata_a;
    logic [BW_DATA-1:0] r_rdata_b;
    logic               r_rvalid;

    logic [BW_DATA-1:0] w_entry_a;
    logic [BW_DATA-1:0] w_entry_b;
    logic [BW_DATA-1:0] w_value_a;
    logic [BW_DATA-1:0] w_value_b;

    assign w_entry_a = r_mem[i_raddr_a];
    assign w_entry_b = r_mem[i_raddr_b];

    reg_file_fwd #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR),
        .BYPASS  (BYPASS)
    ) u_fwd_a (
        .i_addr  (i_raddr_a),
        .i_entry (w_entry_a),
        .i_we    (i_we),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .o_value (w_value_a)
    );

    reg_file_fwd #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR),
        .BYPASS  (BYPASS)
    ) u_fwd_b (
        .i_addr  (i_raddr_b),
        .i_entry (w_entry_b),
        .i_we    (i_we),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .o_value (w_value_b)
    );

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < NUM_REG; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we && (i_waddr != BW_ADDR'(REG_ZERO))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Data holds when no read is requested so the ALU inputs stay stable.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) begin
                r_rdata_a <= w_value_a;
                r_rdata_b <= w_value_b;
            end
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;
    assign o_rvalid  = r_rvalid;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench: one forwarding and one read-old register file share
// the same stimulus and are compared every cycle against an array model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clock = 1'b0;
    logic        rstN  = 1'b0;
    logic        we    = 1'b0;
    logic [4:0]  wAddr = '0;
    logic [31:0] wData = '0;
    logic        re    = 1'b0;
    logic [4:0]  rAddrA = '0;
    logic [4:0]  rAddrB = '0;

    logic [31:0] byRdataA, byRdataB, oldRdataA, oldRdataB;
    logic        byRvalid, oldRvalid;

    int nVectors    = 0;
    int nMiscompares = 0;

    // Model state: architectural contents plus expected outputs per config
    // (index 0 = read-old, index 1 = forwarding).
    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] expA [2] = '{default: 32'h0};
    logic [31:0] expB [2] = '{default: 32'h0};
    logic        expV = 1'b0;

    reg_file #(.BYPASS(1)) dutBypass (
        .i_clk     (clock),
        .i_rstn    (rstN),
        .i_we      (we),
        .i_waddr   (wAddr),
        .i_wdata   (wData),
        .i_re      (re),
        .i_raddr_a (rAddrA),
        .i_raddr_b (rAddrB),
        .o_rdata_a (byRdataA),
        .o_rdata_b (byRdataB),
        .o_rvalid  (byRvalid)
    );

    reg_file #(.BYPASS(0)) dutOld (
        .i_clk     (clock),
        .i_rstn    (rstN),
        .i_we      (we),
        .i_waddr   (wAddr),
        .i_wdata   (wData),
        .i_re      (re),
        .i_raddr_a (rAddrA),
        .i_raddr_b (rAddrB),
        .o_rdata_a (oldRdataA),
        .o_rdata_b (oldRdataB),
        .o_rvalid  (oldRvalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] modelRead(input int bypass, input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (bypass != 0 && we && wAddr == addr) return wData;
        return mem[addr];
    endfunction

    // Reads see the pre-edge array; the write lands afterwards.
    always @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < 32; k++) mem[k] = 32'h0;
            for (int c = 0; c < 2; c++) begin
                expA[c] = 32'h0;
                expB[c] = 32'h0;
            end
            expV = 1'b0;
        end else begin
            if (re) begin
                for (int c = 0; c < 2; c++) begin
                    expA[c] = modelRead(c, rAddrA);
                    expB[c] = modelRead(c, rAddrB);
                end
            end
            expV = re;
            if (we && wAddr != 5'd0) mem[wAddr] = wData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        checkOutput("bypass.rdata_a", byRdataA, expA[1]);
        checkOutput("bypass.rdata_b", byRdataB, expB[1]);
        checkOutput("bypass.rvalid", {31'h0, byRvalid}, {31'h0, expV});
        checkOutput("old.rdata_a", oldRdataA, expA[0]);
        checkOutput("old.rdata_b", oldRdataB, expB[0]);
        checkOutput("old.rvalid", {31'h0, oldRvalid}, {31'h0, expV});
    end

    // Drives one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input logic iWe, input logic [4:0] iWAddr,
                                 input logic [31:0] iWData, input logic iRe,
                                 input logic [4:0] iRA, input logic [4:0] iRB);
        @(negedge clock);
        #1;
        we = iWe; wAddr = iWAddr; wData = iWData;
        re = iRe; rAddrA = iRA; rAddrB = iRB;
    endtask

    task automatic afterEdge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] reg_file bench starting");
        afterEdge();
        checkOutput("reset.rdata_a", byRdataA, 32'h0);
        checkOutput("reset.rvalid", {31'h0, byRvalid}, 32'h0);
        @(negedge clock);
        #1 rstN = 1'b1;

        // Reset mid-cycle with live data on the outputs
        applyStimulus(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd3, 5'd3);
        afterEdge();
        checkOutput("preReset.rdata_a", byRdataA, 32'hDEADBEEF);
        #1 rstN = 1'b0;
        #1;
        checkOutput("asyncReset.by.rdata_a", byRdataA, 32'h0);
        checkOutput("asyncReset.old.rdata_a", oldRdataA, 32'h0);
        checkOutput("asyncReset.rvalid", {31'h0, byRvalid}, 32'h0);
        re = 1'b0;
        @(negedge clock);
        #1 rstN = 1'b1;

        applyStimulus(0, 5'd0, 32'h0, 1, 5'd5, 5'd31);
        afterEdge();
        checkOutput("postReset.r5", byRdataA, 32'h0);
        checkOutput("postReset.r31", byRdataB, 32'h0);
        checkOutput("postReset.rvalid", {31'h0, byRvalid}, 32'h1);

        // Write / readback and operand use
        applyStimulus(1, 5'd1, 32'h3, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd2, 32'h5, 0, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd1, 5'd2);
        afterEdge();
        checkOutput("readback.a", byRdataA, 32'h3);
        checkOutput("readback.b", byRdataB, 32'h5);
        checkOutput("model.a", expA[1], 32'h3);
        checkOutput("aluAdd.y", alu_eval(ALU_ADD, byRdataA, byRdataB), 32'h8);

        // r0 immunity, including same-edge write and read of r0
        applyStimulus(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 5'd0);
        afterEdge();
        checkOutput("r0.a", byRdataA, 32'h0);
        checkOutput("r0.b", oldRdataB, 32'h0);

        // Same-edge write/read: forwarding vs read-old
        applyStimulus(1, 5'd7, 32'hAAAAAAAA, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd7, 32'h12345678, 1, 5'd7, 5'd0);
        afterEdge();
        checkOutput("fwd.bypass", byRdataA, 32'h12345678);
        checkOutput("fwd.old", oldRdataA, 32'hAAAAAAAA);
        checkOutput("model.old", expA[0], 32'hAAAAAAAA);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd7, 5'd7);
        afterEdge();
        checkOutput("fwdAfter.bypass", byRdataA, 32'h12345678);
        checkOutput("fwdAfter.old", oldRdataB, 32'h12345678);

        // Hold while idle, with a write landing underneath
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd1, 5'd2);
        applyStimulus(1, 5'd1, 32'h9, 0, 5'd1, 5'd2);
        afterEdge();
        checkOutput("hold.rvalid", {31'h0, byRvalid}, 32'h0);
        checkOutput("hold.a", byRdataA, 32'h3);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd1, 5'd2);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd1, 5'd2);
        afterEdge();
        checkOutput("holdLate.a", oldRdataA, 32'h3);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd1, 5'd2);
        afterEdge();
        checkOutput("holdNext.a", byRdataA, 32'h9);

        // Preload entry[k] = k+1, then stream back-to-back reads
        for (int k = 1; k < 32; k++) begin
            applyStimulus(1, 5'(k), 32'(k + 1), 0, 5'd0, 5'd0);
        end
        for (int j = 0; j < 100; j++) begin
            applyStimulus(0, 5'd0, 32'h0, 1, 5'(j % 32), 5'((2 * j) % 32));
        end
        afterEdge();
        checkOutput("streamLast.a", byRdataA, 32'h4);
        checkOutput("streamLast.b", oldRdataB, 32'h7);
        checkOutput("streamLast.rvalid", {31'h0, oldRvalid}, 32'h1);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        @(negedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
